// File: rtl/alu.sv
// LC-3b datapath ALU: ADD/AND/XOR/PASSA with a tri-state bus gate
// and registered NZP condition codes captured from each gated result.
module alu #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       aluk,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             gate_alu,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       cc
);

    localparam logic [1:0] alu_add = 2'b00;
    localparam logic [1:0] alu_and = 2'b01;
    localparam logic [1:0] alu_xor = 2'b10;
    localparam logic [1:0] alu_a   = 2'b11;

    localparam logic [2:0] cc_rst  = 3'b010;

    logic [WIDTH-1:0] res;
    logic [2:0]       cc_next;
    logic             res_neg;
    logic             res_zero;

    // Zero-latency operation select; ADD wraps modulo 2^WIDTH
    always_comb begin
        res = A;
        case (aluk)
            alu_add: res = WIDTH'(A + B);
            alu_and: res = A & B;
            alu_xor: res = A ^ B;
            alu_a:   res = A;
            default: res = A;
        endcase
    end

    // Bus driver: released to high-Z whenever the gate is off
    assign out = gate_alu ? res : {WIDTH{1'bz}};

    assign res_neg  = res[WIDTH-1];
    assign res_zero = (res == '0);

    // Condition codes follow only results that were actually put on the bus
    always_comb begin
        cc_next = cc;
        if (gate_alu) begin
            cc_next = {res_neg, res_zero, !res_neg && !res_zero};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc <= cc_rst;
        end else begin
            cc <= cc_next;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: vector table for result and NZP capture,
// plus hand sequences for gating, hold and async reset behaviour.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [1:0]  aluk;
    logic [15:0] a;
    logic [15:0] b;
    logic        gate_alu;
    tri1  [15:0] bus;
    logic [2:0]  cc;

    int total;
    int bad;

    typedef struct {
        string       name;
        logic [1:0]  aluk;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_out;
        logic [2:0]  exp_cc;
    } vec_t;

    vec_t vecs[14];

    alu dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .aluk     (aluk),
        .A        (a),
        .B        (b),
        .gate_alu (gate_alu),
        .out      (bus),
        .cc       (cc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;

        vecs[0]  = '{"add_1_2",       2'b00, 16'h0001, 16'h0002, 16'h0003, 3'b001};
        vecs[1]  = '{"add_5_7",       2'b00, 16'h0005, 16'h0007, 16'h000C, 3'b001};
        vecs[2]  = '{"add_wrap",      2'b00, 16'h8000, 16'h8000, 16'h0000, 3'b010};
        vecs[3]  = '{"add_carry",     2'b00, 16'h8456, 16'h8123, 16'h0579, 3'b001};
        vecs[4]  = '{"and_1_2",       2'b01, 16'h0001, 16'h0002, 16'h0000, 3'b010};
        vecs[5]  = '{"and_a_7",       2'b01, 16'h000A, 16'h0007, 16'h0002, 3'b001};
        vecs[6]  = '{"and_ffff_0",    2'b01, 16'hFFFF, 16'h0000, 16'h0000, 3'b010};
        vecs[7]  = '{"and_ffff_bead", 2'b01, 16'hFFFF, 16'hBEAD, 16'hBEAD, 3'b100};
        vecs[8]  = '{"xor_1_2",       2'b10, 16'h0001, 16'h0002, 16'h0003, 3'b001};
        vecs[9]  = '{"xor_a_7",       2'b10, 16'h000A, 16'h0007, 16'h000D, 3'b001};
        vecs[10] = '{"xor_ffff_0",    2'b10, 16'hFFFF, 16'h0000, 16'hFFFF, 3'b100};
        vecs[11] = '{"xor_ffff_bead", 2'b10, 16'hFFFF, 16'hBEAD, 16'h4152, 3'b001};
        vecs[12] = '{"pass_dead",     2'b11, 16'hDEAD, 16'h0000, 16'hDEAD, 3'b100};
        vecs[13] = '{"pass_fa27",     2'b11, 16'hFA27, 16'hBEAD, 16'hFA27, 3'b100};

        rst_n    = 1'b0;
        aluk     = 2'b00;
        a        = 16'h0000;
        b        = 16'h0000;
        gate_alu = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check3("reset_cc", cc, 3'b010);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: result visible before any edge, cc captured on the edge
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            aluk     = vecs[i].aluk;
            a        = vecs[i].a;
            b        = vecs[i].b;
            gate_alu = 1'b1;
            #1;
            check16({vecs[i].name, "_out"}, bus, vecs[i].exp_out);
            @(posedge clk);
            #1;
            check3({vecs[i].name, "_cc"}, cc, vecs[i].exp_cc);
        end

        // Negative result via gated ADD 8000h + 0
        @(negedge clk);
        aluk = 2'b00; a = 16'h8000; b = 16'h0000; gate_alu = 1'b1;
        @(posedge clk);
        #1;
        check3("cc_neg", cc, 3'b100);

        // Gate off: bus released, edge must not disturb cc
        @(negedge clk);
        aluk = 2'b00; a = 16'h0001; b = 16'h0002; gate_alu = 1'b0;
        #1;
        check16("gate_off_out", bus, 16'hFFFF);
        @(posedge clk);
        #1;
        check3("gate_off_hold", cc, 3'b100);
        @(negedge clk);
        a = 16'h0000; b = 16'h0000;
        @(posedge clk);
        #1;
        check3("gate_off_hold_zero", cc, 3'b100);

        // Re-assert gate between edges: result appears immediately
        #1;
        a = 16'h0001; b = 16'h0002;
        gate_alu = 1'b1;
        #1;
        check16("gate_on_out", bus, 16'h0003);
        gate_alu = 1'b0;
        #1;
        check16("gate_drop_out", bus, 16'hFFFF);
        gate_alu = 1'b1;
        #1;
        check16("gate_again_out", bus, 16'h0003);
        @(posedge clk);
        #1;
        check3("cc_pos", cc, 3'b001);

        // Async reset mid-cycle forces Z without a clock edge
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check3("async_reset_cc", cc, 3'b010);
        check16("reset_out_unaffected", bus, 16'h0003);
        @(posedge clk);
        #1;
        check3("reset_held_cc", cc, 3'b010);
        @(negedge clk);
        rst_n = 1'b1;
        a = 16'hF000; b = 16'h0000;
        @(posedge clk);
        #1;
        check3("post_reset_capture", cc, 3'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
